// File: rtl/usb_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : usb_bus_ctrl
// Purpose  : CPU memory-bus slave that turns 32-bit accesses into one or two
//            timed 16-bit cycles on the USB host chip's async parallel bus,
//            and sequences the chip reset. Build option USB_IRQ_SYNC_EN adds
//            a 2-flop synchronizer for the chip interrupt (irq tied 0 otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module usb_bus_ctrl #(
  parameter int SETUP_CYCLES    = 1,
  parameter int STROBE_CYCLES   = 3,
  parameter int HOLD_CYCLES     = 1,
  parameter int RECOVERY_CYCLES = 2,
  parameter int RESET_CYCLES    = 100
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        mem_cmd_sel,
  input  logic        mem_cmd_valid,
  output logic        mem_cmd_ready,
  input  logic        mem_cmd_wr,
  input  logic [17:0] mem_cmd_addr,
  input  logic [31:0] mem_cmd_wdata,
  input  logic [3:0]  mem_cmd_be,
  output logic        mem_rsp_ready,
  output logic [31:0] mem_rsp_rdata,
  output logic        usb_reset_,
  output logic        usb_cs_,
  output logic        usb_rd_,
  output logic        usb_wr_,
  output logic [16:0] usb_a,
  output logic        usb_d_oe,
  output logic [15:0] usb_d_out,
  input  logic [15:0] usb_d_in,
  input  logic        usb_irq,
  output logic        irq
);

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    IDLE     = 3'd1,
    SETUP    = 3'd2,
    STROBE   = 3'd3,
    HOLD     = 3'd4,
    RECOVER  = 3'd5
  } state_t;

  localparam logic [15:0] C_SETUP_LD   = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] C_STROBE_LD  = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] C_HOLD_LD    = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] C_RECOVER_LD = 16'(RECOVERY_CYCLES - 1);
  localparam logic [15:0] C_RESET_LD   = 16'(RESET_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_wr;
  logic        r_half;
  logic        r_pending;
  logic [15:0] r_wdata_hi;
  logic [15:0] r_rd_lo;
  logic [15:0] r_rd_hi;

  logic w_accept;
  logic w_lo_en;
  logic w_hi_en;
  logic w_unused;

  assign w_accept = (r_state == IDLE) && mem_cmd_ready && mem_cmd_valid && mem_cmd_sel;
  // Reads always take both halves; writes skip a half whose byte enables are all clear.
  assign w_lo_en  = !mem_cmd_wr || (mem_cmd_be[1:0] != 2'b00);
  assign w_hi_en  = !mem_cmd_wr || (mem_cmd_be[3:2] != 2'b00);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state       <= RST_HOLD;
      r_cnt         <= C_RESET_LD;
      r_wr          <= 1'b0;
      r_half        <= 1'b0;
      r_pending     <= 1'b0;
      r_wdata_hi    <= 16'd0;
      r_rd_lo       <= 16'd0;
      r_rd_hi       <= 16'd0;
      mem_cmd_ready <= 1'b0;
      mem_rsp_ready <= 1'b0;
      mem_rsp_rdata <= 32'd0;
      usb_reset_    <= 1'b0;
      usb_cs_       <= 1'b1;
      usb_rd_       <= 1'b1;
      usb_wr_       <= 1'b1;
      usb_a         <= 17'd0;
      usb_d_oe      <= 1'b0;
      usb_d_out     <= 16'd0;
    end else begin
      mem_rsp_ready <= 1'b0;
      case (r_state)
        RST_HOLD: begin
          if (r_cnt == 16'd0) begin
            r_state       <= IDLE;
            usb_reset_    <= 1'b1;
            mem_cmd_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        IDLE: begin
          if (w_accept) begin
            mem_cmd_ready <= 1'b0;
            r_wr          <= mem_cmd_wr;
            r_wdata_hi    <= mem_cmd_wdata[31:16];
            // A write with no enabled bytes stays here; ready comes back next cycle.
            if (w_lo_en || w_hi_en) begin
              r_state   <= SETUP;
              r_cnt     <= C_SETUP_LD;
              r_half    <= !w_lo_en;
              r_pending <= w_lo_en && w_hi_en;
              usb_cs_   <= 1'b0;
              usb_a     <= {mem_cmd_addr[17:2], !w_lo_en};
              usb_d_oe  <= mem_cmd_wr;
              usb_d_out <= w_lo_en ? mem_cmd_wdata[15:0] : mem_cmd_wdata[31:16];
            end
          end else begin
            mem_cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          if (r_cnt == 16'd0) begin
            r_state <= STROBE;
            r_cnt   <= C_STROBE_LD;
            usb_rd_ <= r_wr;
            usb_wr_ <= !r_wr;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        STROBE: begin
          if (r_cnt == 16'd0) begin
            r_state <= HOLD;
            r_cnt   <= C_HOLD_LD;
            usb_rd_ <= 1'b1;
            usb_wr_ <= 1'b1;
            if (!r_wr) begin
              if (r_half) r_rd_hi <= usb_d_in;
              else        r_rd_lo <= usb_d_in;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        HOLD: begin
          if (r_cnt == 16'd0) begin
            if (r_pending) begin
              r_state   <= SETUP;
              r_cnt     <= C_SETUP_LD;
              r_half    <= 1'b1;
              r_pending <= 1'b0;
              usb_a[0]  <= 1'b1;
              usb_d_out <= r_wdata_hi;
            end else begin
              r_state  <= RECOVER;
              r_cnt    <= C_RECOVER_LD;
              usb_cs_  <= 1'b1;
              usb_d_oe <= 1'b0;
              if (!r_wr) begin
                mem_rsp_ready <= 1'b1;
                mem_rsp_rdata <= {r_rd_hi, r_rd_lo};
              end
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        RECOVER: begin
          if (r_cnt == 16'd0) begin
            r_state       <= IDLE;
            r_cnt         <= 16'd0;
            mem_cmd_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_state <= RST_HOLD;
          r_cnt   <= C_RESET_LD;
        end
      endcase
    end
  end

`ifdef USB_IRQ_SYNC_EN
  logic r_irq_meta;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_irq_meta <= 1'b0;
      irq        <= 1'b0;
    end else begin
      r_irq_meta <= usb_irq;
      irq        <= r_irq_meta && (r_state != RST_HOLD);
    end
  end

  assign w_unused = ^mem_cmd_addr[1:0];
`else
  assign irq      = 1'b0;
  assign w_unused = ^{mem_cmd_addr[1:0], usb_irq};
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_bus_ctrl.sv
`default_nettype none
// Bench for usb_bus_ctrl: directed scenarios plus random traffic, every cycle
// compared against a waveform-level model built from the bus timing rules.
module tb_usb_bus_ctrl;
  localparam int SETUP_CYCLES    = 1;
  localparam int STROBE_CYCLES   = 3;
  localparam int HOLD_CYCLES     = 1;
  localparam int RECOVERY_CYCLES = 2;
  localparam int RESET_CYCLES    = 100;

  logic        clk = 1'b0;
  logic        reset_;
  logic        mem_cmd_sel, mem_cmd_valid, mem_cmd_wr;
  logic [17:0] mem_cmd_addr;
  logic [31:0] mem_cmd_wdata;
  logic [3:0]  mem_cmd_be;
  logic        mem_cmd_ready, mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;
  logic        usb_reset_, usb_cs_, usb_rd_, usb_wr_;
  logic [16:0] usb_a;
  logic        usb_d_oe;
  logic [15:0] usb_d_out, usb_d_in;
  logic        usb_irq, irq;

  logic [15:0] chip_mem [256];
  assign usb_d_in = usb_rd_ ? 16'h0000 : chip_mem[usb_a[7:0]];

  usb_bus_ctrl #(
    .SETUP_CYCLES(SETUP_CYCLES), .STROBE_CYCLES(STROBE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .RECOVERY_CYCLES(RECOVERY_CYCLES), .RESET_CYCLES(RESET_CYCLES)
  ) dut (
    .clk(clk), .reset_(reset_),
    .mem_cmd_sel(mem_cmd_sel), .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_wr(mem_cmd_wr), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
    .mem_cmd_be(mem_cmd_be), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata),
    .usb_reset_(usb_reset_), .usb_cs_(usb_cs_), .usb_rd_(usb_rd_), .usb_wr_(usb_wr_),
    .usb_a(usb_a), .usb_d_oe(usb_d_oe), .usb_d_out(usb_d_out), .usb_d_in(usb_d_in),
    .usb_irq(usb_irq), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [16:0] a;
    logic        oe;
    logic [15:0] dout;
    logic        rdy;
    logic        rsp;
    logic [31:0] rdata;
  } exp_t;

  exp_t cur;
  exp_t plan[$];
  int   rst_left;
  logic m_meta, m_irq;
  int   checks = 0;
  int   errors = 0;
  logic last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    cur = '0;
    cur.cs = 1'b1;
    cur.rd = 1'b1;
    cur.wr = 1'b1;
    plan.delete();
    rst_left = RESET_CYCLES;
    m_meta = 1'b0;
    m_irq  = 1'b0;
  endfunction

  // Expands one accepted command into its full per-cycle output waveform.
  function automatic void build_plan(input exp_t base);
    exp_t e;
    int   nh;
    logic en;
    e = base; e.rdy = 1'b0; e.rsp = 1'b0; nh = 0;
    for (int h = 0; h < 2; h++) begin
      en = !mem_cmd_wr || ((h == 0) ? (mem_cmd_be[1:0] != 2'b00) : (mem_cmd_be[3:2] != 2'b00));
      if (en) begin
        nh++;
        e.a    = {mem_cmd_addr[17:2], (h == 1)};
        e.dout = (h == 1) ? mem_cmd_wdata[31:16] : mem_cmd_wdata[15:0];
        e.cs   = 1'b0;
        e.oe   = mem_cmd_wr;
        e.rd = 1'b1; e.wr = 1'b1;
        for (int i = 0; i < SETUP_CYCLES; i++) plan.push_back(e);
        e.rd = mem_cmd_wr; e.wr = !mem_cmd_wr;
        for (int i = 0; i < STROBE_CYCLES; i++) plan.push_back(e);
        e.rd = 1'b1; e.wr = 1'b1;
        for (int i = 0; i < HOLD_CYCLES; i++) plan.push_back(e);
      end
    end
    e.cs = 1'b1; e.oe = 1'b0;
    if (nh == 0) plan.push_back(e);
    else begin
      for (int r = 0; r < RECOVERY_CYCLES; r++) begin
        e.rsp = (r == 0) && !mem_cmd_wr;
        if (e.rsp)
          e.rdata = {chip_mem[{mem_cmd_addr[8:2], 1'b1}], chip_mem[{mem_cmd_addr[8:2], 1'b0}]};
        plan.push_back(e);
      end
    end
  endfunction

  function automatic void model_edge();
    logic in_hold;
    exp_t base;
    if (!reset_) begin
      model_reset();
      return;
    end
    in_hold = (rst_left > 0);
`ifdef USB_IRQ_SYNC_EN
    m_irq  = in_hold ? 1'b0 : m_meta;
    m_meta = usb_irq;
`endif
    if (in_hold) begin
      rst_left--;
      if (rst_left == 0) begin
        cur.rst = 1'b1;
        cur.rdy = 1'b1;
      end
      return;
    end
    base = cur;
    base.rsp = 1'b0;
    if (cur.rdy && mem_cmd_valid && mem_cmd_sel) build_plan(base);
    if (plan.size() > 0) cur = plan.pop_front();
    else begin
      cur = base;
      cur.cs = 1'b1; cur.rd = 1'b1; cur.wr = 1'b1; cur.oe = 1'b0; cur.rdy = 1'b1;
    end
  endfunction

  task automatic compare();
    chk("usb_reset_", 32'(usb_reset_), 32'(cur.rst));
    chk("usb_cs_", 32'(usb_cs_), 32'(cur.cs));
    chk("usb_rd_", 32'(usb_rd_), 32'(cur.rd));
    chk("usb_wr_", 32'(usb_wr_), 32'(cur.wr));
    chk("usb_a", 32'(usb_a), 32'(cur.a));
    chk("usb_d_oe", 32'(usb_d_oe), 32'(cur.oe));
    if (cur.oe) chk("usb_d_out", 32'(usb_d_out), 32'(cur.dout));
    chk("mem_cmd_ready", 32'(mem_cmd_ready), 32'(cur.rdy));
    chk("mem_rsp_ready", 32'(mem_rsp_ready), 32'(cur.rsp));
    chk("mem_rsp_rdata", mem_rsp_rdata, cur.rdata);
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic step();
    last_acc = mem_cmd_ready && mem_cmd_valid && mem_cmd_sel;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    mem_cmd_valid = 1'b0;
    mem_cmd_sel   = 1'b0;
  endtask

  task automatic set_cmd(input logic wr, input logic [17:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
    mem_cmd_valid = 1'b1; mem_cmd_sel = 1'b1;
    mem_cmd_wr = wr; mem_cmd_addr = addr; mem_cmd_wdata = wd; mem_cmd_be = be;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!mem_cmd_ready && n < 300) begin step(); n++; end
    chk(name, 32'(mem_cmd_ready), 32'd1);
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 50) begin step(); n++; end
    chk(name, 32'(last_acc), 32'd1);
  endtask

  task automatic rand_inputs();
    mem_cmd_valid = ($urandom_range(0, 2) != 0);
    mem_cmd_sel   = ($urandom_range(0, 3) != 0);
    mem_cmd_wr    = 1'($urandom_range(0, 1));
    mem_cmd_addr  = 18'($urandom);
    mem_cmd_wdata = $urandom;
    mem_cmd_be    = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
    if ($urandom_range(0, 9) == 0) usb_irq = ~usb_irq;
  endtask

  initial begin
    int n, n0, lat, rdlow, wrlow, oecnt, rspcnt, cshigh, accepts;
    logic [16:0] a_first, a_last;
    logic [15:0] d_seen;
    logic got;

    reset_ = 1'b0;
    usb_irq = 1'b0;
    mem_cmd_wr = 1'b0; mem_cmd_addr = '0; mem_cmd_wdata = '0; mem_cmd_be = '0;
    idle_inputs();
    for (int i = 0; i < 256; i++) chip_mem[i] = 16'($urandom);
    chip_mem[8] = 16'h1234;
    chip_mem[9] = 16'hABCD;
    model_reset();

    repeat (3) step();
    chk("reset_outputs", 32'({usb_reset_, usb_cs_, usb_rd_, usb_wr_, usb_d_oe, mem_cmd_ready,
                              mem_rsp_ready, irq}), 32'b0111_0000);
    chk("reset_addr_rdata", 32'(usb_a) | mem_rsp_rdata | 32'(usb_d_out), 32'd0);

    // Chip reset sequence after release.
    reset_ = 1'b1;
    n = 0;
    while (!usb_reset_ && n < 300) begin step(); n++; end
    chk("usb_reset_len", 32'(n), 32'd100);
    chk("ready_after_reset", 32'(mem_cmd_ready), 32'd1);
    chk("strobes_after_reset", 32'({usb_cs_, usb_rd_, usb_wr_}), 32'b111);

    // Read 0x00010: chip returns 0x1234 then 0xABCD.
    set_cmd(1'b0, 18'h00010, 32'h5555AAAA, 4'h0);
    wait_accept("rd_accept");
    idle_inputs();
    lat = 1; rdlow = 0; a_first = '1; a_last = '0; got = 1'b0;
    while (!got && lat < 40) begin
      step(); lat++;
      if (!usb_rd_) begin
        if (rdlow == 0) a_first = usb_a;
        a_last = usb_a;
        rdlow++;
      end
      if (mem_rsp_ready) got = 1'b1;
    end
    chk("rd_latency", 32'(lat), 32'd11);
    chk("rd_rdata", mem_rsp_rdata, 32'hABCD1234);
    chk("rd_strobe_cycles", 32'(rdlow), 32'd6);
    chk("rd_addr_low", 32'(a_first), 32'h00008);
    chk("rd_addr_high", 32'(a_last), 32'h00009);
    wait_ready("rd_ready_back");

    // Write 0x00004 = 0xDEADBEEF with only the upper half enabled.
    set_cmd(1'b1, 18'h00004, 32'hDEADBEEF, 4'b1100);
    wait_accept("wr_accept");
    idle_inputs();
    wrlow = 0; oecnt = 0; rspcnt = 0; a_first = '0; d_seen = '0;
    for (int i = 0; i < 12; i++) begin
      if (usb_d_oe) oecnt++;
      if (mem_rsp_ready) rspcnt++;
      if (!usb_wr_) begin wrlow++; a_first = usb_a; d_seen = usb_d_out; end
      step();
    end
    chk("wr_strobe_cycles", 32'(wrlow), 32'd3);
    chk("wr_oe_cycles", 32'(oecnt), 32'd5);
    chk("wr_no_rsp", 32'(rspcnt), 32'd0);
    chk("wr_addr", 32'(a_first), 32'h00003);
    chk("wr_data", 32'(d_seen), 32'h0000DEAD);
    wait_ready("wr_ready_back");

    // Back-to-back writes with valid&sel held high.
    set_cmd(1'b1, 18'h00100, 32'h0BAD_F00D, 4'b0011);
    n = 0; n0 = 0; accepts = 0; cshigh = 0;
    while (accepts < 2 && n < 60) begin
      step(); n++;
      if (last_acc) begin
        accepts++;
        if (accepts == 1) n0 = n;
        else n0 = n - n0;
      end else if (accepts == 1 && usb_cs_) cshigh++;
    end
    chk("b2b_gap", 32'(n0), 32'd8);
    chk("b2b_cs_high", 32'(cshigh), 32'd3);
    wait_ready("b2b_ready");
    mem_cmd_be = 4'h0;
    n = 0; n0 = 0; accepts = 0;
    while (accepts < 2 && n < 60) begin
      step(); n++;
      if (last_acc) begin
        accepts++;
        if (accepts == 1) n0 = n;
        else n0 = n - n0;
      end
    end
    chk("be0_gap", 32'(n0), 32'd2);
    idle_inputs();
    wait_ready("be0_ready");

    // Reset asserted in the second STROBE cycle of a read.
    set_cmd(1'b0, 18'h00010, 32'h0, 4'h0);
    wait_accept("rst_rd_accept");
    idle_inputs();
    step(); step();
    chk("rst_rd_in_strobe", 32'(usb_rd_), 32'd0);
    reset_ = 1'b0;
    model_reset();
    #1;
    chk("rst_immediate", 32'({usb_reset_, usb_cs_, usb_rd_, mem_cmd_ready}), 32'b0110);
    compare();
    rspcnt = 0;
    repeat (3) begin step(); if (mem_rsp_ready) rspcnt++; end
    reset_ = 1'b1;
    n = 0;
    while (!mem_cmd_ready && n < 300) begin step(); n++; if (mem_rsp_ready) rspcnt++; end
    chk("rst_no_rsp", 32'(rspcnt), 32'd0);
    chk("rst_rerun_len", 32'(n), 32'd100);

    // Interrupt path.
    usb_irq = 1'b1;
    n = 0;
    while (!irq && n < 6) begin step(); n++; end
`ifdef USB_IRQ_SYNC_EN
    chk("irq_latency", 32'(n), 32'd2);
`else
    chk("irq_tied_low", 32'(irq), 32'd0);
`endif
    usb_irq = 1'b0;
    repeat (4) step();

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      if ($urandom_range(0, 999) == 0) begin
        reset_ = 1'b0;
        model_reset();
        #1;
        compare();
        step();
        reset_ = 1'b1;
      end
      step();
    end
    idle_inputs();
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual time %0t, required < 2000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
